// File: rtl/dsp_result_collector.sv
// Captures DSP_top results at the predicted latency, tags them in issue order and buffers them in a FIFO.
// Optional drop counter enabled by defining DSP_COLLECT_DROPCNT_EN.
module dsp_result_collector #(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned PIPE_STAGE_WIDTH = 2,
    parameter int unsigned BASE_LATENCY     = 1,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned TAG_WIDTH        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic                        mac,
    input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
    input  logic [2*WIDTH-1:0]          dsp_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2*WIDTH-1:0]          res_data,
    output logic [TAG_WIDTH-1:0]        res_tag,
    output logic [2:0]                  res_mode,
    output logic                        busy,
`ifdef DSP_COLLECT_DROPCNT_EN
    output logic [7:0]                  drop_count,
`endif
    output logic                        overflow,
    output logic                        cfg_err
);

    localparam int unsigned DW         = 2 * WIDTH;
    localparam int unsigned LINE_DEPTH = BASE_LATENCY + (2 ** PIPE_STAGE_WIDTH) - 1;
    localparam int unsigned LIDX_W     = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    // In-flight line: one entry per cycle since issue
    logic                 line_valid   [LINE_DEPTH];
    logic [TAG_WIDTH-1:0] line_tag     [LINE_DEPTH];
    logic [2:0]           line_meta    [LINE_DEPTH];
    logic                 line_valid_n [LINE_DEPTH];
    logic [TAG_WIDTH-1:0] line_tag_n   [LINE_DEPTH];
    logic [2:0]           line_meta_n  [LINE_DEPTH];

    logic [DW-1:0]        fifo_data [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
    logic [2:0]           fifo_meta [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_n;

    logic [TAG_WIDTH-1:0]        tag_cnt;
    logic [PIPE_STAGE_WIDTH-1:0] ps_q;
    logic [LIDX_W-1:0]           tap_idx;
    logic                        tap_valid;
    logic                        cfg_change;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        push_ok;
    logic                        drop;
    logic                        busy_n;

    // Tap selection, flush detection and FIFO handshake decode
    always_comb begin
        tap_idx    = LIDX_W'(BASE_LATENCY - 1) + LIDX_W'(pipe_stages);
        tap_valid  = line_valid[tap_idx];
        cfg_change = busy && (pipe_stages != ps_q);
        push       = tap_valid && !cfg_change;
        pop        = res_valid && res_ready;
        full       = (count == CNT_W'(FIFO_DEPTH));
        push_ok    = push && (!full || pop);
        drop       = push && full && !pop;

        count_n = count;
        if (push_ok && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_n = count - CNT_W'(1);
        end
    end

    // Next state of the in-flight line; entries past the tap retire so busy drops after capture
    always_comb begin
        busy_n = 1'b0;
        for (int i = 0; i < int'(LINE_DEPTH); i++) begin
            line_valid_n[i] = 1'b0;
            line_tag_n[i]   = '0;
            line_meta_n[i]  = '0;
        end
        line_valid_n[0] = start;
        line_tag_n[0]   = tag_cnt;
        line_meta_n[0]  = {mac, mode};
        for (int i = 1; i < int'(LINE_DEPTH); i++) begin
            line_valid_n[i] = line_valid[i-1] && (LIDX_W'(i - 1) < tap_idx);
            line_tag_n[i]   = line_tag[i-1];
            line_meta_n[i]  = line_meta[i-1];
        end
        if (cfg_change) begin
            for (int i = 0; i < int'(LINE_DEPTH); i++) begin
                line_valid_n[i] = 1'b0;
            end
        end
        for (int i = 0; i < int'(LINE_DEPTH); i++) begin
            busy_n = busy_n | line_valid_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LINE_DEPTH); i++) begin
                line_valid[i] <= 1'b0;
                line_tag[i]   <= '0;
                line_meta[i]  <= '0;
            end
            busy    <= 1'b0;
            tag_cnt <= '0;
            ps_q    <= '0;
        end else begin
            for (int i = 0; i < int'(LINE_DEPTH); i++) begin
                line_valid[i] <= line_valid_n[i];
                line_tag[i]   <= line_tag_n[i];
                line_meta[i]  <= line_meta_n[i];
            end
            busy <= busy_n;
            ps_q <= pipe_stages;
            if (start) begin
                tag_cnt <= tag_cnt + TAG_WIDTH'(1);
            end
        end
    end

    // Result FIFO with registered valid: a push into an empty FIFO shows up one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
                fifo_meta[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_data[wr_ptr] <= dsp_out;
                fifo_tag[wr_ptr]  <= line_tag[tap_idx];
                fifo_meta[wr_ptr] <= line_meta[tap_idx];
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_n;
            res_valid <= (count_n != '0);
        end
    end

    always_comb begin
        res_data = fifo_data[rd_ptr];
        res_tag  = fifo_tag[rd_ptr];
        res_mode = fifo_meta[rd_ptr];
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (cfg_change) begin
                cfg_err <= 1'b1;
            end
        end
    end

`ifdef DSP_COLLECT_DROPCNT_EN
    // Saturating count of results lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Scoreboard bench for dsp_result_collector: directed ops queue expected results, a monitor checks each pop.
module tb_dsp_result_collector;

    localparam int unsigned WIDTH            = 16;
    localparam int unsigned PIPE_STAGE_WIDTH = 2;
    localparam int unsigned BASE_LATENCY     = 1;
    localparam int unsigned FIFO_DEPTH       = 8;
    localparam int unsigned TAG_WIDTH        = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic [2:0]  mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        mac;
    logic [1:0]  pipe_stages;
    logic [31:0] dsp_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic [2:0]  res_mode;
    logic        busy;
    logic        overflow;
    logic        cfg_err;
`ifdef DSP_COLLECT_DROPCNT_EN
    logic [7:0]  drop_count;
`endif

    exp_t        sbq[$];
    logic [31:0] outval[int];
    logic [3:0]  exp_tag;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    dsp_result_collector #(
        .WIDTH(WIDTH), .PIPE_STAGE_WIDTH(PIPE_STAGE_WIDTH), .BASE_LATENCY(BASE_LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .mac(mac),
        .pipe_stages(pipe_stages), .dsp_out(dsp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_mode(res_mode), .busy(busy),
`ifdef DSP_COLLECT_DROPCNT_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow), .cfg_err(cfg_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // DSP output model: the scheduled word is on dsp_out just before its capture edge
    initial begin
        dsp_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (outval.exists(cyc)) dsp_out = outval[cyc];
            else dsp_out = {16'hDEAD, cyc[15:0]};
        end
    end

    // Monitor: every accepted head must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got data=%h tag=%0d mode=%b, required no result", res_data, res_tag, res_mode);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (res_data !== e.data || res_tag !== e.tag || res_mode !== e.mode) begin
                    n_fail++;
                    $display("FAIL result: got data=%h tag=%0d mode=%b, required data=%h tag=%0d mode=%b",
                             res_data, res_tag, res_mode, e.data, e.tag, e.mode);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        exp_tag = '0;
    endtask

    task automatic issue(input logic m_mac, input logic [1:0] m_mode, input logic [31:0] d, input bit expect_cap);
        exp_t e;
        start = 1'b1;
        mac   = m_mac;
        mode  = m_mode;
        outval[cyc + int'(BASE_LATENCY) + int'(pipe_stages)] = d;
        if (expect_cap) begin
            e.data = d;
            e.tag  = exp_tag;
            e.mode = {m_mac, m_mode};
            sbq.push_back(e);
        end
        exp_tag = exp_tag + 4'd1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; mac = 1'b0; pipe_stages = '0; res_ready = 1'b1;
        exp_tag = '0;
        repeat (3) tick();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        rst = 1'b0;
        tick();

        // Single op, minimum latency
        issue(1'b0, 2'd0, 32'h0000_1234, 1'b1);
        check("t1_busy_inflight", 32'(busy), 32'd1);
        check("t1_no_early_valid", 32'(res_valid), 32'd0);
        tick();
        check("t1_busy_after_capture", 32'(busy), 32'd0);
        check("t1_res_valid", 32'(res_valid), 32'd1);
        repeat (3) tick();
        check("t1_drained", 32'(res_valid), 32'd0);

        // Four back-to-back ops at latency 4; idle config change stays silent
        do_reset();
        pipe_stages = 2'd3;
        tick();
        for (int k = 0; k < 4; k++) issue(1'b0, 2'd1, 32'h100 + 32'(k), 1'b1);
        repeat (8) tick();
        check("t2_cfg_err_idle", 32'(cfg_err), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // Overflow: 10 ops into an 8-deep FIFO, then push+pop on a full FIFO
        do_reset();
        pipe_stages = 2'd0;
        res_ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) issue(1'b1, 2'd0, 32'h200 + 32'(k), k < 8);
        repeat (2) tick();
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_res_valid_full", 32'(res_valid), 32'd1);
        check("t3_head_stable", res_data, 32'h200);
`ifdef DSP_COLLECT_DROPCNT_EN
        check("t3_drop_count", 32'(drop_count), 32'd2);
`endif
        issue(1'b1, 2'd1, 32'h2AA, 1'b1);
        res_ready = 1'b1;
        repeat (12) tick();
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        check("t3_empty_after_drain", 32'(res_valid), 32'd0);
`ifdef DSP_COLLECT_DROPCNT_EN
        check("t3_drop_count_no_new_drop", 32'(drop_count), 32'd2);
`endif

        // Config change with two ops in flight flushes them, keeps the FIFO
        do_reset();
        pipe_stages = 2'd1;
        res_ready = 1'b0;
        tick();
        issue(1'b0, 2'd3, 32'h55, 1'b1);
        repeat (3) tick();
        check("t4_prior_valid", 32'(res_valid), 32'd1);
        issue(1'b0, 2'd0, 32'h66, 1'b0);
        issue(1'b0, 2'd0, 32'h67, 1'b0);
        pipe_stages = 2'd3;
        repeat (6) tick();
        check("t4_cfg_err", 32'(cfg_err), 32'd1);
        check("t4_busy_flushed", 32'(busy), 32'd0);
        check("t4_prior_kept", res_data, 32'h55);
        res_ready = 1'b1;
        repeat (2) tick();
        check("t4_no_flushed_results", 32'(res_valid), 32'd0);
        do_reset();
        pipe_stages = 2'd2;
        repeat (2) tick();
        check("t4_cfg_err_idle", 32'(cfg_err), 32'd0);

        // Reset one cycle after issue discards the op; start during reset is ignored
        do_reset();
        pipe_stages = 2'd3;
        tick();
        issue(1'b0, 2'd1, 32'h77, 1'b0);
        do_reset();
        repeat (8) tick();
        check("t5_no_result", 32'(res_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        sbq.delete();
        exp_tag = '0;
        pipe_stages = 2'd0;
        tick();
        issue(1'b1, 2'd2, 32'h88, 1'b1);
        repeat (3) tick();

        // 17 ops: tag wraps, last one is mac=1 mode=2 with tag 0
        do_reset();
        pipe_stages = 2'd0;
        res_ready = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            if (k == 16) issue(1'b1, 2'd2, 32'h300 + 32'(k), 1'b1);
            else issue(k[0], k[2:1], 32'h300 + 32'(k), 1'b1);
        end
        repeat (4) tick();
        check("t6_all_results_seen", 32'(sbq.size()), 32'd0);
        check("t6_empty", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
